// File: rtl/pad_halfduplex_uart_if.sv
// rtl/pad_halfduplex_uart_if.sv - core/pad signal bundle for the half-duplex single-wire UART
interface pad_halfduplex_uart_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       busy;
   logic       pad_p2c;
   logic       pad_c2p;
   logic       pad_c2p_en;

   modport master (
      output tx_data, tx_valid, pad_p2c,
      input  tx_ready, rx_data, rx_valid, rx_err, busy, pad_c2p, pad_c2p_en
   );

   modport slave (
      input  tx_data, tx_valid, pad_p2c,
      output tx_ready, rx_data, rx_valid, rx_err, busy, pad_c2p, pad_c2p_en
   );
endinterface

// File: rtl/pad_halfduplex_uart.sv
// rtl/pad_halfduplex_uart.sv - single-wire half-duplex 8N1 UART driving one bidirectional pad cell
module pad_halfduplex_uart #(
   parameter int CLKS_PER_BIT = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   pad_halfduplex_uart_if.slave  bus
);
   localparam int            CW          = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX_BIT,
      S_TURN,
      S_RX_START,
      S_RX_BIT,
      S_RX_STOP
   } state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [CW-1:0]          r_cnt;
   logic [3:0]             r_idx;
   logic [8:0]             r_tx_frame;
   logic [7:0]             r_rx_shift;
   logic [7:0]             r_rx_data;
   logic                   r_rx_valid;
   logic                   r_rx_err;
   logic                   r_tx_ready;
   logic                   r_busy;
   logic                   r_c2p;
   logic                   r_c2p_en;

   logic                   w_rx;
   logic                   w_start;
   logic                   w_bit_end;

   assign w_rx      = r_sync[SYNC_STAGES-1];
   assign w_start   = r_prev & ~w_rx;
   assign w_bit_end = (r_cnt == C_BIT_LAST);

   // Reset to mark level so releasing reset never looks like a start edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pad_p2c};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_prev     <= 1'b1;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_tx_frame <= '1;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_rx_err   <= 1'b0;
         r_tx_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_c2p      <= 1'b1;
         r_c2p_en   <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_rx_err   <= 1'b0;
         r_prev     <= w_rx;
         r_cnt      <= r_cnt + 1'b1;

         case (r_state)
            S_IDLE: begin
               r_cnt      <= '0;
               r_idx      <= '0;
               r_tx_ready <= 1'b1;
               if (w_start) begin
                  r_state    <= S_RX_START;
                  r_tx_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end else if (bus.tx_valid && r_tx_ready) begin
                  r_state    <= S_TX_BIT;
                  r_tx_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_tx_frame <= {1'b1, bus.tx_data};
                  r_c2p      <= 1'b0;
                  r_c2p_en   <= 1'b1;
               end
            end

            // Own echo on the shared line must never be taken as a start edge
            S_TX_BIT: begin
               r_prev <= 1'b1;
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_idx == 4'd9) begin
                     r_state  <= S_TURN;
                     r_idx    <= '0;
                     r_c2p    <= 1'b1;
                     r_c2p_en <= 1'b0;
                  end else begin
                     r_idx      <= r_idx + 4'd1;
                     r_c2p      <= r_tx_frame[0];
                     r_tx_frame <= {1'b1, r_tx_frame[8:1]};
                  end
               end
            end

            S_TURN: begin
               r_prev <= 1'b1;
               if (w_bit_end) begin
                  r_state    <= S_IDLE;
                  r_cnt      <= '0;
                  r_busy     <= 1'b0;
                  r_tx_ready <= 1'b1;
               end
            end

            S_RX_START: begin
               if (r_cnt == C_HALF_LAST) begin
                  r_cnt <= '0;
                  if (!w_rx) begin
                     r_state <= S_RX_BIT;
                  end else begin
                     r_state    <= S_IDLE;
                     r_busy     <= 1'b0;
                     r_tx_ready <= 1'b1;
                  end
               end
            end

            S_RX_BIT: begin
               if (w_bit_end) begin
                  r_cnt      <= '0;
                  r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                  if (r_idx == 4'd7) begin
                     r_idx   <= '0;
                     r_state <= S_RX_STOP;
                  end else begin
                     r_idx <= r_idx + 4'd1;
                  end
               end
            end

            S_RX_STOP: begin
               if (w_bit_end) begin
                  r_cnt      <= '0;
                  r_state    <= S_IDLE;
                  r_busy     <= 1'b0;
                  r_tx_ready <= 1'b1;
                  if (w_rx) begin
                     r_rx_data  <= r_rx_shift;
                     r_rx_valid <= 1'b1;
                  end else begin
                     r_rx_err <= 1'b1;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.tx_ready   = r_tx_ready;
   assign bus.rx_data    = r_rx_data;
   assign bus.rx_valid   = r_rx_valid;
   assign bus.rx_err     = r_rx_err;
   assign bus.busy       = r_busy;
   assign bus.pad_c2p    = r_c2p;
   assign bus.pad_c2p_en = r_c2p_en;
endmodule

// File: tb/tb_pad_halfduplex_uart.sv
// tb/tb_pad_halfduplex_uart.sv - self-checking bench for pad_halfduplex_uart
module tb_pad_halfduplex_uart;
   localparam int CPB  = 16;
   localparam int K_RX = 0;
   localparam int K_GL = 1;
   localparam int K_TX = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
      logic       stop_bit;
      int         glitch_len;
      int         exp_valid;
      int         exp_err;
      logic [7:0] exp_data;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tb_line = 1'b1;
   int         n_checks = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         nvalid = 0;
   int         nerr = 0;
   int         last_rx_cyc = 0;
   int         tx_start_cyc = 0;
   int         en_rises = 0;
   logic       both_seen = 1'b0;
   logic       en_prev = 1'b0;
   int         tcnt = 0;
   logic [9:0] tbits = '1;
   logic [7:0] txq[$];
   int         txlen[$];
   logic       txok[$];
   vec_t       vecs[$];

   pad_halfduplex_uart_if u_if ();

   // Open-drain style line: DUT drive overrides, otherwise the bench (or the pull-up) sets the level
   assign u_if.pad_p2c = u_if.pad_c2p_en ? u_if.pad_c2p : tb_line;

   pad_halfduplex_uart #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (u_if.rx_valid) begin
         nvalid      <= nvalid + 1;
         last_rx_cyc <= cyc;
      end
      if (u_if.rx_err) nerr <= nerr + 1;
      if (u_if.rx_valid && u_if.rx_err) both_seen <= 1'b1;
   end

   // Line-level UART decoder: samples the driven pad mid-bit, counted from the enable rise
   always @(negedge clk) begin
      en_prev <= u_if.pad_c2p_en;
      if (u_if.pad_c2p_en) begin
         if (!en_prev) begin
            tcnt         <= 1;
            tx_start_cyc <= cyc;
            en_rises     <= en_rises + 1;
         end else begin
            if ((tcnt % CPB) == CPB / 2 && tcnt < 10 * CPB) tbits[tcnt / CPB] <= u_if.pad_c2p;
            tcnt <= tcnt + 1;
         end
      end else if (en_prev) begin
         txq.push_back(tbits[8:1]);
         txlen.push_back(tcnt);
         txok.push_back(tbits[0] == 1'b0 && tbits[9] == 1'b1);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (u_if.tx_ready) break;
      end
      check(name, u_if.tx_ready, 1);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!u_if.busy && u_if.tx_ready) break;
      end
      check(name, {u_if.busy, u_if.tx_ready}, 2'b01);
   endtask

   task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input bit collide,
                              input logic [7:0] txd);
      logic [9:0] f;
      f = {stop_bit, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < CPB; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) tb_line = f[b];
            if (collide && b == 0 && c == 2) begin
               u_if.tx_data  = txd;
               u_if.tx_valid = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1 tb_line = 1'b1;
   endtask

   task automatic drive_glitch(input int len);
      @(posedge clk);
      #1 tb_line = 1'b0;
      repeat (len) @(posedge clk);
      #1 tb_line = 1'b1;
   endtask

   task automatic send_tx(input logic [7:0] d);
      wait_ready("tx_ready before send");
      @(posedge clk);
      #1;
      u_if.tx_data  = d;
      u_if.tx_valid = 1'b1;
      @(posedge clk);
      #1 u_if.tx_valid = 1'b0;
      wait_idle("tx completion");
   endtask

   function automatic vec_t mk(input int kind, input logic [7:0] d, input logic sb, input int gl);
      vec_t v;
      v.kind       = kind;
      v.data       = d;
      v.stop_bit   = sb;
      v.glitch_len = gl;
      v.exp_valid  = 0;
      v.exp_err    = 0;
      v.exp_data   = '0;
      return v;
   endfunction

   task automatic apply(input vec_t v, input int idx);
      int v0, e0, r0;
      v0 = nvalid;
      e0 = nerr;
      r0 = en_rises;
      case (v.kind)
         K_RX:    drive_frame(v.data, v.stop_bit, 1'b0, 8'h00);
         K_GL:    drive_glitch(v.glitch_len);
         default: send_tx(v.data);
      endcase
      idle(3 * CPB);
      check($sformatf("vec%0d rx_valid pulses", idx), nvalid - v0, v.exp_valid);
      check($sformatf("vec%0d rx_err pulses", idx), nerr - e0, v.exp_err);
      check($sformatf("vec%0d rx_data", idx), u_if.rx_data, v.exp_data);
      check($sformatf("vec%0d idle busy/ready", idx), {u_if.busy, u_if.tx_ready}, 2'b01);
      if (v.kind == K_TX) begin
         check($sformatf("vec%0d tx frames", idx), en_rises - r0, 1);
         if (txq.size() > 0) begin
            check($sformatf("vec%0d tx byte", idx), txq.pop_front(), v.data);
            check($sformatf("vec%0d tx drive length", idx), txlen.pop_front(), 10 * CPB);
            check($sformatf("vec%0d tx start/stop", idx), txok.pop_front(), 1);
         end
      end else begin
         check($sformatf("vec%0d pad drive during rx", idx), en_rises - r0, 0);
      end
   endtask

   initial begin
      int         a5_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
      logic       en_k[181];
      logic       c2p_k[181];
      logic       rdy_k[181];
      int         first_rdy, en_hi, en_lo, v0, e0, r0;
      logic [7:0] m_last;

      u_if.tx_data  = 8'h00;
      u_if.tx_valid = 1'b0;

      repeat (4) @(posedge clk);
      @(negedge clk);
      check("reset pad_c2p_en", u_if.pad_c2p_en, 0);
      check("reset pad_c2p", u_if.pad_c2p, 1);
      check("reset tx_ready", u_if.tx_ready, 0);
      check("reset rx_data", u_if.rx_data, 0);
      check("reset rx_valid", u_if.rx_valid, 0);
      check("reset rx_err", u_if.rx_err, 0);
      check("reset busy", u_if.busy, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post-reset tx_ready", u_if.tx_ready, 1);
      check("post-reset busy", u_if.busy, 0);

      // TX 0xA5, cycle k counted from the acceptance edge
      @(posedge clk);
      #1;
      u_if.tx_data  = 8'hA5;
      u_if.tx_valid = 1'b1;
      @(posedge clk);
      #1 u_if.tx_valid = 1'b0;
      for (int k = 1; k <= 180; k++) begin
         @(negedge clk);
         en_k[k]  = u_if.pad_c2p_en;
         c2p_k[k] = u_if.pad_c2p;
         rdy_k[k] = u_if.tx_ready;
      end
      first_rdy = -1;
      en_hi     = 0;
      en_lo     = 0;
      for (int k = 1; k <= 180; k++) begin
         if (rdy_k[k] && first_rdy < 0) first_rdy = k;
         if (k <= 160 && en_k[k]) en_hi++;
         if (k > 160 && k <= 176 && !en_k[k]) en_lo++;
      end
      for (int b = 0; b < 10; b++) check($sformatf("A5 bit%0d", b), c2p_k[16 * b + 8], a5_seq[b]);
      check("A5 drive cycles", en_hi, 160);
      check("A5 turnaround cycles", en_lo, 16);
      check("A5 tx_ready return cycle", first_rdy, 177);
      wait_idle("A5 idle");
      txq.delete();
      txlen.delete();
      txok.delete();

      vecs.push_back(mk(K_RX, 8'h3C, 1'b1, 0));
      vecs.push_back(mk(K_RX, 8'h55, 1'b0, 0));
      vecs.push_back(mk(K_GL, 8'h00, 1'b1, 5));
      vecs.push_back(mk(K_TX, 8'hC3, 1'b1, 0));
      vecs.push_back(mk(K_RX, 8'h00, 1'b1, 0));
      vecs.push_back(mk(K_RX, 8'hFF, 1'b1, 0));
      vecs.push_back(mk(K_RX, 8'h81, 1'b0, 0));
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk($urandom_range(0, 2), 8'($urandom_range(0, 255)),
                           1'($urandom_range(0, 1)), $urandom_range(1, 6)));

      // Reference: good frames update the held byte, bad stop bits only flag, glitches and TX do nothing
      m_last = 8'h00;
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].kind == K_RX) begin
            if (vecs[i].stop_bit) begin
               vecs[i].exp_valid = 1;
               m_last            = vecs[i].data;
            end else begin
               vecs[i].exp_err = 1;
            end
         end
         vecs[i].exp_data = m_last;
      end
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Reset in the middle of a transmission
      v0 = nvalid;
      e0 = nerr;
      wait_ready("midtx ready");
      @(posedge clk);
      #1;
      u_if.tx_data  = 8'h5A;
      u_if.tx_valid = 1'b1;
      @(posedge clk);
      #1 u_if.tx_valid = 1'b0;
      repeat (40) @(negedge clk);
      check("midtx driving", u_if.pad_c2p_en, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midtx rst pad_c2p_en", u_if.pad_c2p_en, 0);
      check("midtx rst pad_c2p", u_if.pad_c2p, 1);
      check("midtx rst busy/ready", {u_if.busy, u_if.tx_ready}, 2'b00);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midtx release ready", u_if.tx_ready, 1);
      idle(2 * CPB);
      check("midtx no rx report", (nvalid - v0) + (nerr - e0), 0);
      txq.delete();
      txlen.delete();
      txok.delete();

      // tx_valid raised in the cycle the synchronized start edge reaches the detector
      v0 = nvalid;
      r0 = en_rises;
      drive_frame(8'h96, 1'b1, 1'b1, 8'h3A);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (u_if.pad_c2p_en) break;
      end
      u_if.tx_valid = 1'b0;
      check("collision tx started", u_if.pad_c2p_en, 1);
      wait_idle("collision idle");
      idle(2);
      check("collision rx pulses", nvalid - v0, 1);
      check("collision rx_data", u_if.rx_data, 8'h96);
      check("collision tx frames", en_rises - r0, 1);
      check("collision rx before tx", tx_start_cyc > last_rx_cyc, 1);
      if (txq.size() > 0) check("collision tx byte", txq.pop_front(), 8'h3A);

      check("rx_valid with rx_err", both_seen, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/pad_halfduplex_uart.md
Name: pad_halfduplex_uart

Overview:
- Core-side single-wire, half-duplex serial port.
- Consumes and drives one bidirectional IO pad cell through its three core-side pins: c2p (data to pad), c2p_en (output enable) and p2c (data from pad).
- Sits directly behind the sg13g2_IOPadInOut4mA instance in the chip top.
- Sends bytes from the core, and receives bytes from the pad, as 8N1 frames on the shared line.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per bit. Legal range ≥4. Mid-bit offset is CLKS_PER_BIT/2, using integer division.
- SYNC_STAGES, 2: number of flops in the pad_p2c synchronizer. Legal range ≥2.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- tx_data  in  8  byte to transmit
- tx_valid  in  1  transmit request
- tx_ready  out  1  block can accept tx_data
- rx_data  out  8  last good received byte; held until the next rx_valid
- rx_valid  out  1  one-cycle pulse: rx_data updated
- rx_err  out  1  one-cycle pulse: framing error or aborted frame
- busy  out  1  high in any state other than IDLE
- pad_p2c  in  1  pad input (asynchronous)
- pad_c2p  out  1  pad output data
- pad_c2p_en  out  1  pad output enable; 1 = drive the line

Behaviour:
- Reset: rst is sampled at a clk edge; outputs take reset values on that edge.
  - Reset values: pad_c2p_en=0, pad_c2p=1, tx_ready=0, rx_data=0, rx_valid=0, rx_err=0, busy=0.
  - Synchronizer flops and the previous-sample flop reset to 1, so no false start edge is seen.
  - Reset mid-frame aborts the frame immediately and releases the pad. Nothing is reported.
  - First cycle after reset: state is IDLE and tx_ready=1.
- Line convention:
  - Idle/mark level is 1. The board pull-up holds the line high while released.
  - Frame format: start bit 0, 8 data bits LSB first, stop bit 1.
- States: IDLE, TX_BIT, TURN, RX_START, RX_BIT, RX_STOP.
- IDLE:
  - pad_c2p_en=0 and tx_ready=1.
  - A start edge is a synchronized 1→0 transition.
  - If a start edge is detected: go to RX_START and set tx_ready=0 on the same edge.
  - Otherwise, if tx_valid=1: latch tx_data, go to TX_BIT, set tx_ready=0.
  - Simultaneous start edge and tx_valid: RX wins. tx_valid stays pending, because it is not accepted while tx_ready=0.
- TX_BIT:
  - Acceptance happens at edge N. From cycle N+1, pad_c2p_en=1 and pad_c2p=0 (start bit).
  - Each of the 10 bits is driven for exactly CLKS_PER_BIT cycles.
  - Total drive time is 10*CLKS_PER_BIT cycles; the last driven bit is the stop bit (1).
  - Then go to TURN.
  - Synchronized input is ignored throughout TX_BIT (own echo).
- TURN:
  - pad_c2p_en=0 for CLKS_PER_BIT cycles (bus turnaround).
  - Input is still ignored.
  - The previous-sample flop is forced to 1, so the release glitch cannot be taken as a start edge.
  - Then go to IDLE.
- RX_START:
  - Wait CLKS_PER_BIT/2 cycles, then sample.
  - Sample 0: go to RX_BIT.
  - Sample 1: glitch. Return to IDLE silently, with no rx_err.
- RX_BIT:
  - Sample every CLKS_PER_BIT cycles after the start sample, 8 samples in total.
  - Shift LSB first into an internal register. rx_data is not touched during the frame.
- RX_STOP:
  - Sample one CLKS_PER_BIT period after the last data sample.
  - Sample 1: the cycle after the sample, rx_data ← shift register and rx_valid=1 for one cycle.
  - Sample 0: rx_err=1 for one cycle and rx_data is unchanged.
  - Either way, return to IDLE. The next start requires a fresh 1→0 edge.
- Input latency: a pad change reaches the edge detector after SYNC_STAGES cycles.
- Counters:
  - Bit-time counter width is $clog2(CLKS_PER_BIT).
  - Bit index counter is 4 bits.
  - Both reset to 0 on every state entry.
- rx_valid and rx_err are never high together.

Test Plan:
- Reset hold, then release:
  - During reset: pad_c2p_en=0, pad_c2p=1, tx_ready=0.
  - First cycle after: tx_ready=1, busy=0.
- TX 0xA5 with CLKS_PER_BIT=16:
  - pad_c2p sequence per 16-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - pad_c2p_en=1 for 160 cycles, then 0 for 16 cycles.
  - tx_ready returns to 1 at cycle 177 after acceptance.
- RX 0x3C driven on pad_p2c at 16 cycles/bit:
  - Exactly one rx_valid pulse, with rx_data=0x3C.
  - rx_err stays 0 and pad_c2p_en stays 0.
- RX frame 0x55 with the stop bit forced to 0:
  - rx_err pulses once.
  - rx_data keeps its prior value; rx_valid stays 0.
- pad_p2c low pulse of 5 cycles:
  - No rx_valid and no rx_err; returns to IDLE.
- Collision cases:
  - tx_valid asserted in the same cycle the synchronized start edge appears: the RX frame completes first, then the TX frame starts.
  - rst asserted mid-TX: pad_c2p_en=0 on the rst edge.
